// File: rtl/lcd_time_writer_pkg.sv
// Shared recorder package: FSM state encoding, ASCII constants and the
// column layout of the "R mm:ss  P mm:ss" status line.
package lcd_time_writer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } lcd_state_e;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_P     = 8'h50;
  localparam logic [7:0] ASCII_ZERO  = 8'h30;

  localparam logic [3:0] COL_REC_TAG    = 4'd0;
  localparam logic [3:0] COL_REC_MIN1   = 4'd2;
  localparam logic [3:0] COL_REC_MIN0   = 4'd3;
  localparam logic [3:0] COL_REC_COLON  = 4'd4;
  localparam logic [3:0] COL_REC_SEC1   = 4'd5;
  localparam logic [3:0] COL_REC_SEC0   = 4'd6;
  localparam logic [3:0] COL_PLAY_TAG   = 4'd9;
  localparam logic [3:0] COL_PLAY_MIN1  = 4'd11;
  localparam logic [3:0] COL_PLAY_MIN0  = 4'd12;
  localparam logic [3:0] COL_PLAY_COLON = 4'd13;
  localparam logic [3:0] COL_PLAY_SEC1  = 4'd14;
  localparam logic [3:0] COL_PLAY_SEC0  = 4'd15;
  localparam logic [3:0] COL_LAST       = 4'd15;

endpackage

// File: rtl/lcd_time_writer_digit_char.sv
// BCD nibble to ASCII: 0-9 become '0'-'9', anything else becomes '?'.
module lcd_digit_char
  import lcd_time_writer_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [7:0] char_o
);

  // Decimal digits map onto the ASCII digit range; invalid BCD is flagged visibly.
  always_comb begin
    char_o = ASCII_QMARK;
    if (digit_i <= 4'd9) begin
      char_o = ASCII_ZERO + {4'd0, digit_i};
    end else begin
      char_o = ASCII_QMARK;
    end
  end

endmodule

// File: rtl/lcd_time_writer.sv
// Streams the record/play times as one 16-column LCD line from a snapshot.
// Optional colon blinking is enabled by defining LCD_COLON_BLINK_EN.
module lcd_time_writer
  import lcd_time_writer_pkg::*;
#(
  parameter int REFRESH_CYCLES = 5000000,
  parameter int BLINK_CYCLES   = 25000000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] i_record_time,
  input  logic [15:0] i_play_time,
  output logic        o_char_valid,
  output logic [3:0]  o_char_addr,
  output logic [7:0]  o_char_data,
  input  logic        i_char_ready,
  output logic        o_busy,
  output logic        o_frame_done
);

  localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [REF_W-1:0] REF_MAX = REF_W'(REFRESH_CYCLES - 1);

  lcd_state_e       state_q;
  logic [15:0]      snap_rec_q;
  logic [15:0]      snap_play_q;
  logic [REF_W-1:0] refresh_q;
  logic             first_q;
  logic             valid_q;
  logic             busy_q;
  logic             done_q;
  logic [3:0]       addr_q;
  logic [7:0]       data_q;

  logic [3:0]  addr_d;
  logic [7:0]  char_d;
  logic [7:0]  colon_chr;
  logic        trigger_d;
  logic        start_d;
  logic        expired_d;
  logic        changed_d;
  logic [31:0] snap_all;
  logic [7:0]  digit_chr [8];

  assign snap_all  = {snap_rec_q, snap_play_q};
  assign changed_d = (i_record_time != snap_rec_q) || (i_play_time != snap_play_q);
  assign expired_d = (refresh_q == REF_MAX);
  assign start_d   = (state_q == IDLE) && trigger_d;
  assign addr_d    = addr_q + 4'd1;

  // Digit k converts snapshot nibble k; k=7 is record min_1, k=0 is play sec_0.
  for (genvar k = 0; k < 8; k++) begin : g_digit
    lcd_digit_char u_digit (
      .digit_i (snap_all[4*k +: 4]),
      .char_o  (digit_chr[k])
    );
  end

`ifdef LCD_COLON_BLINK_EN
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_CYCLES - 1);

  logic [BL_W-1:0] blink_q;
  logic            phase_q;
  logic            blink_pend_q;
  logic            snap_phase_q;

  // Half-period timer; each toggle leaves a pending request for a rewrite.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      blink_q      <= '0;
      phase_q      <= 1'b0;
      blink_pend_q <= 1'b0;
      snap_phase_q <= 1'b0;
    end else begin
      if (start_d) snap_phase_q <= phase_q;
      if (blink_q == BL_MAX) begin
        blink_q      <= '0;
        phase_q      <= ~phase_q;
        blink_pend_q <= 1'b1;
      end else begin
        blink_q <= blink_q + 1'b1;
        if (start_d) blink_pend_q <= 1'b0;
      end
    end
  end

  assign colon_chr = snap_phase_q ? ASCII_SPACE : ASCII_COLON;
  assign trigger_d = first_q || changed_d || expired_d || blink_pend_q;
`else
  assign colon_chr = ASCII_COLON;
  assign trigger_d = first_q || changed_d || expired_d;
`endif

  // Character for the column after the current one, taken from the snapshot.
  always_comb begin
    char_d = ASCII_SPACE;
    case (addr_d)
      COL_REC_TAG:                   char_d = ASCII_R;
      COL_REC_MIN1:                  char_d = digit_chr[7];
      COL_REC_MIN0:                  char_d = digit_chr[6];
      COL_REC_COLON, COL_PLAY_COLON: char_d = colon_chr;
      COL_REC_SEC1:                  char_d = digit_chr[5];
      COL_REC_SEC0:                  char_d = digit_chr[4];
      COL_PLAY_TAG:                  char_d = ASCII_P;
      COL_PLAY_MIN1:                 char_d = digit_chr[3];
      COL_PLAY_MIN0:                 char_d = digit_chr[2];
      COL_PLAY_SEC1:                 char_d = digit_chr[1];
      COL_PLAY_SEC0:                 char_d = digit_chr[0];
      default:                       char_d = ASCII_SPACE;
    endcase
  end

  // Frame sequencer; all outputs are registered here.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      snap_rec_q  <= '0;
      snap_play_q <= '0;
      refresh_q   <= '0;
      first_q     <= 1'b1;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= ASCII_SPACE;
    end else begin
      if (start_d) begin
        refresh_q <= '0;
      end else if (!expired_d) begin
        refresh_q <= refresh_q + 1'b1;
      end
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (trigger_d) begin
            snap_rec_q  <= i_record_time;
            snap_play_q <= i_play_time;
            first_q     <= 1'b0;
            state_q     <= SEND;
            valid_q     <= 1'b1;
            busy_q      <= 1'b1;
            addr_q      <= COL_REC_TAG;
            data_q      <= ASCII_R;
          end
        end
        SEND: begin
          if (valid_q && i_char_ready) begin
            if (addr_q == COL_LAST) begin
              state_q <= DONE;
              valid_q <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              addr_q <= addr_d;
              data_q <= char_d;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_char_valid = valid_q;
  assign o_char_addr  = addr_q;
  assign o_char_data  = data_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: doc/lcd_time_writer.md
LCD_TIME_WRITER -- requirements
Module: lcd_time_writer

Interface
REQ-001 Parameter REFRESH_CYCLES, default 5000000, forces a full-line rewrite after this many cycles without one (10 Hz at 50 MHz).
REQ-002 Parameter BLINK_CYCLES, default 25000000, sets the colon half-period; used only when LCD_COLON_BLINK_EN is defined.
REQ-003 Port i_clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port i_rst, input, 1: reset, synchronous and active-high.
REQ-005 Port i_record_time, input, 16: BCD {min_1, min_0, sec_1, sec_0} record time from the upstream time core.
REQ-006 Port i_play_time, input, 16: BCD {min_1, min_0, sec_1, sec_0} play time from the upstream time core.
REQ-007 Port o_char_valid, output, 1: character write request to the LCD controller.
REQ-008 Port o_char_addr, output, 4: DDRAM column 0..15 of line 1.
REQ-009 Port o_char_data, output, 8: ASCII character.
REQ-010 Port i_char_ready, input, 1: the LCD controller accepts the character when o_char_valid && i_char_ready.
REQ-011 Port o_busy, output, 1: high while a frame is in progress.
REQ-012 Port o_frame_done, output, 1: one-cycle pulse after column 15 is accepted.

Function
REQ-013 The line layout SHALL be "R mm:ss  P mm:ss": col0 'R', col1 ' ', col2-3 record minutes, col4 ':', col5-6 record seconds, col7-8 ' ', col9 'P', col10 ' ', col11-12 play minutes, col13 ':', col14-15 play seconds.
REQ-014 A BCD digit 0-9 SHALL map to 8'h30+digit, and a digit 10-15 SHALL map to '?' (8'h3F).
REQ-015 The FSM states SHALL be IDLE, SEND, and DONE.
REQ-016 In IDLE, a frame SHALL trigger when either time input differs from the last-written snapshot, when the refresh counter reaches REFRESH_CYCLES-1, or on the first IDLE cycle after reset.
REQ-017 On a trigger, both inputs SHALL be captured into the snapshot, and the next cycle SHALL be SEND with o_char_valid=1 and o_char_addr=0 (latency of 1 cycle).
REQ-018 Every character of a frame SHALL come from the snapshot; input changes during a frame SHALL NOT tear the line.
REQ-019 While o_char_valid && !i_char_ready, o_char_addr and o_char_data SHALL hold stable.
REQ-020 On each accept, the address SHALL increment, and the next character SHALL be presented the following cycle (throughput of 1 character per cycle).
REQ-021 After the column-15 accept, the FSM SHALL enter DONE for one cycle with o_frame_done=1 and o_char_valid=0, then return to IDLE.
REQ-022 A change during SEND SHALL cause a new frame immediately after DONE, because the live inputs differ from the snapshot.
REQ-023 The refresh counter SHALL clear at every frame start and saturate at REFRESH_CYCLES-1.
REQ-024 A change and a refresh expiry in the same cycle SHALL start one frame only.
REQ-025 o_busy SHALL be 1 in SEND and DONE.

Reset
REQ-026 With i_rst high at a clock edge, the FSM SHALL go to IDLE, and o_char_valid, o_busy, o_frame_done, and o_char_addr SHALL be 0.
REQ-027 o_char_data SHALL reset to 8'h20, and the snapshot, refresh counter, and blink counter SHALL reset to 0.
REQ-028 Reset mid-frame SHALL abort the frame with no further accepts, and the first post-reset frame SHALL restart at column 0.

Configuration
REQ-029 With LCD_COLON_BLINK_EN defined, cols 4 and 13 SHALL show ':' during the first half-period and ' ' during the next, toggling every BLINK_CYCLES.
REQ-030 Each colon phase toggle SHALL also trigger a frame.
REQ-031 Without LCD_COLON_BLINK_EN, the colons SHALL be constant ':', and no blink counter SHALL exist.

Structure
REQ-032 The shared recorder package SHALL hold the FSM state enum, the ASCII constants (space, colon, '?', 'R', 'P', digit base), and the line-layout column constants.
REQ-033 One sub-module, lcd_digit_char, SHALL implement the combinational BCD-nibble-to-ASCII mapping of REQ-014.

Verification
REQ-034 Reset, then i_char_ready=1 with times 16'h0000/16'h0000 -> 16 accepts reading "R 00:00  P 00:00", then o_frame_done pulses once.
REQ-035 i_record_time 16'h0159 changed in IDLE -> o_char_valid rises the next cycle, and col5-6 read '5','9'.
REQ-036 i_char_ready low for 3 cycles at col 7 -> addr 7 and data 8'h20 held stable for all 4 cycles, with no skipped or duplicated columns.
REQ-037 i_play_time 16'h0001 changed to 16'h0002 at col 3 -> the current frame shows "01", and a second frame starting right after DONE shows "02".
REQ-038 i_record_time 16'h00A0 -> col5 reads 8'h3F.
REQ-039 i_rst pulsed at col 9 -> the next cycle has o_char_valid=0 and o_busy=0, and the next frame starts at addr 0.
